sap_core: RTL

Parametrised SAP-class processor core: the next generation of the SAP-1 datapath, with internal program/data RAM, a variable-length microsequencer, store, immediate, jump and output instructions, and carry/zero flags. It sits at the top of the chip design, takes the board clock directly, and exposes a program-load port, a run/halt handshake and a registered output port. The datapath width and the address space scale with `DATA_W`.

---
 rtl/sap_core.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sap_core.sv
// sap_core: SAP-class processor core with internal program/data RAM,
// a variable-length microsequencer (F0/F1/E0/E1), and a registered output port.
// Optional feature macro: SAP_CORE_COND_JUMP_EN adds the C/Z flags and enables JC/JZ.
module sap_core #(
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned ADDR_W = DATA_W - 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned SUM_W = DATA_W + 1;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_E0,
    S_E1,
    S_HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] acc;
  logic              c_flag;
  logic              z_flag;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              loadable;
  logic [SUM_W-1:0]  sum_add;
  logic [SUM_W-1:0]  sum_sub;

  assign opcode   = ir[DATA_W-1 -: 4];
  assign operand  = ir[ADDR_W-1:0];
  assign loadable = (state == S_IDLE) || (state == S_HALT);
  assign mem_rd   = mem[mar];
  assign pc_out   = pc;

  // Arithmetic at DATA_W+1 bits; subtraction is A + ~M + 1 so carry means no borrow
  assign sum_add = {1'b0, acc} + {1'b0, mem_rd};
  assign sum_sub = {1'b0, acc} + {1'b0, ~mem_rd} + SUM_W'(1);

  // RAM write port shared by STA (in E1) and the program loader (IDLE/HALT only)
  assign mem_we    = !rst && (((state == S_E1) && (opcode == OP_STA)) || (prog_we && loadable));
  assign mem_waddr = loadable ? prog_addr : mar;
  assign mem_wdata = loadable ? prog_data : acc;

  // RAM storage: not reset, written on the clock edge
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

`ifdef SAP_CORE_COND_JUMP_EN
  // Carry/zero flags, updated only when ADD or SUB completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (state == S_E1) begin
      if (opcode == OP_ADD) begin
        c_flag <= sum_add[DATA_W];
        z_flag <= (sum_add[DATA_W-1:0] == '0);
      end else if (opcode == OP_SUB) begin
        c_flag <= sum_sub[DATA_W];
        z_flag <= (sum_sub[DATA_W-1:0] == '0);
      end
    end
  end
`else
  // Without flags JC/JZ never take, and the carry bits have no consumer
  logic unused_carry;
  assign c_flag       = 1'b0;
  assign z_flag       = 1'b0;
  assign unused_carry = sum_add[DATA_W] ^ sum_sub[DATA_W];
`endif

  // Microsequencer and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (run) begin
            state  <= S_F0;
            pc     <= '0;
            halted <= 1'b0;
          end
        end
        S_F0: begin
          mar   <= pc;
          state <= S_F1;
        end
        S_F1: begin
          ir    <= mem_rd;
          pc    <= pc + ADDR_W'(1);
          state <= S_E0;
        end
        S_E0: begin
          state <= S_F0;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar   <= operand;
              state <= S_E1;
            end
            OP_LDI: acc <= DATA_W'(operand);
            OP_JMP: pc  <= operand;
            OP_JC:  if (c_flag) pc <= operand;
            OP_JZ:  if (z_flag) pc <= operand;
            OP_OUT: begin
              out_data  <= acc;
              out_valid <= 1'b1;
            end
            OP_HLT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: ;
          endcase
        end
        S_E1: begin
          state <= S_F0;
          case (opcode)
            OP_LDA:  acc <= mem_rd;
            OP_ADD:  acc <= sum_add[DATA_W-1:0];
            OP_SUB:  acc <= sum_sub[DATA_W-1:0];
            default: ;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
